// File: rtl/updown_load_counter_pkg.sv
// Shared widths and the per-cycle operation encoding for the up/down/load counter.
package updown_load_counter_pkg;

  localparam int COUNT_WIDTH_DEFAULT = 16;
  localparam int LOAD_WIDTH_DEFAULT  = 16;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLEAR,
    OP_LOAD,
    OP_UP,
    OP_DOWN
  } counter_op_e;

endpackage

// File: rtl/updown_load_counter.sv
// Synchronous WIDTH-bit modular counter with clear, parallel load and up/down counting.
// o_overflow pulses for one cycle alongside the wrapped count value.
module updown_load_counter
  import updown_load_counter_pkg::*;
#(
  parameter int WIDTH      = COUNT_WIDTH_DEFAULT,
  parameter int LOAD_WIDTH = LOAD_WIDTH_DEFAULT
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clr,
  input  logic                  i_en,
  input  logic                  i_load,
  input  logic                  i_down,
  input  logic [LOAD_WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0]      o_count,
  output logic                  o_overflow
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] loadValSized;
  counter_op_e      op;

  // Wider load values keep their LSBs; narrower ones are zero-extended.
  if (LOAD_WIDTH >= WIDTH) begin : g_load_trunc
    assign loadValSized = i_load_val[WIDTH-1:0];
  end else begin : g_load_ext
    assign loadValSized = {{(WIDTH-LOAD_WIDTH){1'b0}}, i_load_val};
  end

  always_comb begin
    op         = OP_HOLD;
    count_d    = count_q;
    overflow_d = 1'b0;

    if (i_clr)       op = OP_CLEAR;
    else if (i_load) op = OP_LOAD;
    else if (i_en)   op = i_down ? OP_DOWN : OP_UP;

    unique case (op)
      OP_CLEAR: count_d = '0;
      OP_LOAD:  count_d = loadValSized;
      OP_UP: begin
        count_d    = count_q + WIDTH'(1);
        overflow_d = (count_q == '1);
      end
      OP_DOWN: begin
        count_d    = count_q - WIDTH'(1);
        overflow_d = (count_q == '0);
      end
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_count    = count_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_updown_load_counter.sv
// Scoreboard bench: a 4-bit and a 20-bit counter share stimulus; expected values are
// queued when inputs are driven and compared against the DUTs after the clock edge.
module tb_updown_load_counter;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_clr = 1'b0;
  logic        i_en = 1'b0;
  logic        i_load = 1'b0;
  logic        i_down = 1'b0;
  logic [19:0] loadVal = '0;
  logic [3:0]  count4;
  logic        ovf4;
  logic [19:0] count20;
  logic        ovf20;

  typedef struct {
    logic [31:0] c4;
    logic        o4;
    logic [31:0] c20;
    logic        o20;
  } expect_t;

  expect_t     sbQueue[$];
  logic [31:0] model4 = '0;
  logic [31:0] model20 = '0;
  int          assertCount = 0;
  int          failCount = 0;

  always #5 i_clk = ~i_clk;

  updown_load_counter #(.WIDTH(4), .LOAD_WIDTH(16)) dut4 (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(i_clr), .i_en(i_en), .i_load(i_load),
    .i_down(i_down), .i_load_val(loadVal[15:0]), .o_count(count4), .o_overflow(ovf4)
  );

  updown_load_counter #(.WIDTH(20), .LOAD_WIDTH(20)) dut20 (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(i_clr), .i_en(i_en), .i_load(i_load),
    .i_down(i_down), .i_load_val(loadVal), .o_count(count20), .o_overflow(ovf20)
  );

  // Reference behaviour for one edge: returns {overflow, next count}.
  function automatic logic [32:0] modelStep(input int w, input int lw, input logic [31:0] cur,
                                            input logic rst, input logic clr, input logic en,
                                            input logic load, input logic down,
                                            input logic [31:0] lv);
    logic [63:0] mask, lmask;
    logic [31:0] nxt;
    logic        ovf;
    mask  = (64'd1 << w) - 64'd1;
    lmask = (64'd1 << lw) - 64'd1;
    nxt   = cur;
    ovf   = 1'b0;
    if (rst || clr) nxt = '0;
    else if (load) nxt = lv & lmask[31:0] & mask[31:0];
    else if (en && !down) begin
      nxt = 32'((64'(cur) + 64'd1) & mask);
      ovf = (cur == mask[31:0]);
    end else if (en) begin
      nxt = 32'((64'(cur) + mask) & mask);
      ovf = (cur == 32'd0);
    end
    return {ovf, nxt};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic clr, input logic en,
                               input logic load, input logic down, input logic [19:0] lv);
    logic [32:0] r4, r20;
    expect_t     e;
    i_rst = rst; i_clr = clr; i_en = en; i_load = load; i_down = down; loadVal = lv;
    r4  = modelStep(4, 16, model4, rst, clr, en, load, down, 32'(lv));
    r20 = modelStep(20, 20, model20, rst, clr, en, load, down, 32'(lv));
    model4  = r4[31:0];
    model20 = r20[31:0];
    e.c4 = r4[31:0];  e.o4 = r4[32];
    e.c20 = r20[31:0]; e.o20 = r20[32];
    sbQueue.push_back(e);
  endtask

  task automatic sampleOutputs();
    expect_t e;
    if (sbQueue.size() == 0) begin
      checkOutput("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sbQueue.pop_front();
      checkOutput("cnt4", 32'(count4), e.c4);
      checkOutput("ovf4", 32'(ovf4), 32'(e.o4));
      checkOutput("cnt20", 32'(count20), e.c20);
      checkOutput("ovf20", 32'(ovf20), 32'(e.o20));
    end
  endtask

  task automatic stepCycle(input logic rst, input logic clr, input logic en,
                           input logic load, input logic down, input logic [19:0] lv);
    applyStimulus(rst, clr, en, load, down, lv);
    @(posedge i_clk);
    @(negedge i_clk);
    sampleOutputs();
  endtask

  initial begin
    @(negedge i_clk);

    // Reset held for three cycles, then free-running up count over two 4-bit wraps.
    repeat (3) stepCycle(1, 0, 1, 0, 0, '0);
    checkOutput("rst_cnt4", 32'(count4), 32'd0);
    repeat (34) stepCycle(0, 0, 1, 0, 0, '0);

    // Down count starting from zero wraps to all-ones immediately.
    stepCycle(1, 0, 0, 0, 0, '0);
    repeat (5) stepCycle(0, 0, 1, 0, 1, '0);

    // Load with truncation, count after load, load beating enable.
    stepCycle(0, 0, 0, 1, 0, 20'h000AB);
    stepCycle(0, 0, 1, 0, 0, '0);
    stepCycle(0, 0, 1, 1, 0, 20'h00035);

    // Priority of clear and reset, then a frozen hold.
    stepCycle(0, 0, 0, 1, 0, 20'd7);
    stepCycle(0, 1, 1, 1, 0, 20'd5);
    stepCycle(0, 0, 0, 1, 0, 20'd7);
    stepCycle(1, 1, 1, 0, 0, '0);
    stepCycle(0, 0, 0, 1, 0, 20'd9);
    repeat (10) stepCycle(0, 0, 0, 0, 0, 20'hFFFFF);

    // Direction switch right on the wrap produces back-to-back pulses.
    stepCycle(0, 0, 0, 1, 0, 20'd14);
    stepCycle(0, 0, 1, 0, 0, '0);
    stepCycle(0, 0, 1, 0, 0, '0);
    stepCycle(0, 0, 1, 0, 1, '0);
    stepCycle(0, 0, 1, 0, 1, '0);

    // Wide counter boundaries reached via load instead of a million-cycle free run.
    stepCycle(0, 0, 0, 1, 0, 20'h1FFFF);
    stepCycle(0, 0, 1, 0, 0, '0);
    checkOutput("w20_top3", 32'(count20[19:17]), 32'd1);
    stepCycle(0, 0, 0, 1, 0, 20'hFFFFF);
    stepCycle(0, 0, 1, 0, 0, '0);
    checkOutput("w20_wrap", 32'(ovf20), 32'd1);

    // Random mix of all controls.
    for (int i = 0; i < 60; i++) begin
      stepCycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 1)), 20'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
